fetch_ctrl: RTL and testbench

Instruction-fetch controller for the multi-cycle pipeline. It owns the program counter and drives a single-outstanding-request instruction-memory handshake. It presents each fetched instruction with its incremented PC to decode under a valid/stall handshake. It accepts next-PC redirects from execute (taken branch or jump target) and freezes on HALT.

---
 rtl/fetch_ctrl_if.sv | 35 +++
 rtl/fetch_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_fetch_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// Fetch-controller bundle: execute redirect, decode handoff and instruction-memory handshake.
// Latency: wiring only, no storage.
// Backpressure: decode holds stall high to keep inst/pc_inc presented; memory paces fetch via imem_done.
//
// Signals (master = fetch_ctrl side):
//   redirect, redirect_pc      execute -> fetch   replace the PC this cycle
//   stall                      decode  -> fetch   presented instruction not accepted
//   imem_req, imem_addr        fetch   -> memory  access in progress / its address
//   imem_rdata, imem_done      memory  -> fetch   instruction word / access complete
//   inst, pc_inc, inst_valid   fetch   -> decode  fetched word, its address + 2, valid
//   halted, err                fetch   -> status  HALT consumed / misaligned fetch trap
interface fetch_ctrl_if;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        stall;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_done;
    logic [15:0] inst;
    logic [15:0] pc_inc;
    logic        inst_valid;
    logic        halted;
    logic        err;

    modport master (
        input  redirect, redirect_pc, stall, imem_rdata, imem_done,
        output imem_req, imem_addr, inst, pc_inc, inst_valid, halted, err
    );

    modport slave (
        output redirect, redirect_pc, stall, imem_rdata, imem_done,
        input  imem_req, imem_addr, inst, pc_inc, inst_valid, halted, err
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, issues one memory access at a time, hands words to decode.
// Latency: imem_done in cycle N -> inst_valid in N+1; best case one instruction every 2 cycles.
// Backpressure: stall holds the presented slot (no new access); redirects squash in-flight or presented work.
//
// Ports:
//   clk    system clock, all state on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    fetch_ctrl_if.master (redirect/stall inputs, imem handshake, decode outputs, halted/err)
// Parameter RESET_PC: PC loaded on reset.
// Optional macro ALIGN_CHK_EN: an odd fetch address traps (err=1, halted=1) instead of being fetched.
module fetch_ctrl #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic              clk,
    input  logic              rst_n,
    fetch_ctrl_if.master      bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    // Opcode field value that marks a HALT instruction.
    localparam logic [4:0] OP_HALT = 5'b00000;

    logic [1:0]  r_state;
    logic [15:0] r_pc;
    logic [15:0] r_fetch_addr;
    logic [15:0] r_tgt;
    logic        r_squash;
    logic [15:0] r_inst;
    logic [15:0] r_pc_inc;
    logic        r_inst_valid;
    logic        r_halted;
`ifdef ALIGN_CHK_EN
    logic        r_err;
`endif

    logic [1:0]  w_state;
    logic [15:0] w_pc;
    logic [15:0] w_fetch_addr;
    logic [15:0] w_tgt;
    logic        w_squash;
    logic [15:0] w_inst;
    logic [15:0] w_pc_inc;
    logic        w_inst_valid;
    logic        w_halted;
`ifdef ALIGN_CHK_EN
    logic        w_err;
`endif
    logic        w_enter_fetch;
    logic [15:0] w_fa_plus2;

    // 16-bit add, wraps 16'hFFFE -> 16'h0000.
    assign w_fa_plus2 = r_fetch_addr + 16'd2;

    always_comb begin
        w_state       = r_state;
        w_pc          = r_pc;
        w_fetch_addr  = r_fetch_addr;
        w_tgt         = r_tgt;
        w_squash      = r_squash;
        w_inst        = r_inst;
        w_pc_inc      = r_pc_inc;
        w_inst_valid  = r_inst_valid;
        w_halted      = r_halted;
`ifdef ALIGN_CHK_EN
        w_err         = r_err;
`endif
        // Every path that starts a new memory access raises this so the
        // alignment trap is applied in exactly one place.
        w_enter_fetch = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.redirect) begin
                    w_pc         = bus.redirect_pc;
                    w_fetch_addr = bus.redirect_pc;
                end else begin
                    w_fetch_addr = r_pc;
                end
                w_enter_fetch = 1'b1;
            end

            ST_FETCH: begin
                if (bus.imem_done) begin
                    if (bus.redirect) begin
                        // Completing word is stale; restart at the new target next cycle.
                        w_pc          = bus.redirect_pc;
                        w_fetch_addr  = bus.redirect_pc;
                        w_squash      = 1'b0;
                        w_enter_fetch = 1'b1;
                    end else if (r_squash) begin
                        // A redirect arrived while this access was in flight.
                        w_pc          = r_tgt;
                        w_fetch_addr  = r_tgt;
                        w_squash      = 1'b0;
                        w_enter_fetch = 1'b1;
                    end else begin
                        w_inst       = bus.imem_rdata;
                        w_pc_inc     = w_fa_plus2;
                        w_pc         = w_fa_plus2;
                        w_inst_valid = 1'b1;
                        w_state      = (bus.imem_rdata[15:11] == OP_HALT) ? ST_HALT : ST_WAIT;
                    end
                end else if (bus.redirect) begin
                    // The access cannot be aborted: remember where to go and
                    // drop its data when it completes. Latest redirect wins.
                    w_tgt    = bus.redirect_pc;
                    w_squash = 1'b1;
                end
            end

            ST_WAIT: begin
                if (bus.redirect) begin
                    w_inst_valid  = 1'b0;
                    w_pc          = bus.redirect_pc;
                    w_fetch_addr  = bus.redirect_pc;
                    w_enter_fetch = 1'b1;
                end else if (!bus.stall) begin
                    w_inst_valid  = 1'b0;
                    w_fetch_addr  = r_pc;
                    w_enter_fetch = 1'b1;
                end
            end

            ST_HALT: begin
                // Once halted, nothing but reset has any effect.
                if (!r_halted) begin
                    if (bus.redirect) begin
                        w_inst_valid  = 1'b0;
                        w_pc          = bus.redirect_pc;
                        w_fetch_addr  = bus.redirect_pc;
                        w_enter_fetch = 1'b1;
                    end else if (r_inst_valid && !bus.stall) begin
                        w_inst_valid = 1'b0;
                        w_halted     = 1'b1;
                    end
                end
            end

            default: begin
                w_state = ST_IDLE;
            end
        endcase

        if (w_enter_fetch) begin
            w_state = ST_FETCH;
`ifdef ALIGN_CHK_EN
            // Trap before FETCH is entered so imem_req never asserts for an odd address.
            if (w_fetch_addr[0]) begin
                w_state  = ST_HALT;
                w_err    = 1'b1;
                w_halted = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_pc         <= RESET_PC;
            r_fetch_addr <= 16'h0000;
            r_tgt        <= 16'h0000;
            r_squash     <= 1'b0;
            r_inst       <= 16'h0000;
            r_pc_inc     <= 16'h0000;
            r_inst_valid <= 1'b0;
            r_halted     <= 1'b0;
`ifdef ALIGN_CHK_EN
            r_err        <= 1'b0;
`endif
        end else begin
            r_state      <= w_state;
            r_pc         <= w_pc;
            r_fetch_addr <= w_fetch_addr;
            r_tgt        <= w_tgt;
            r_squash     <= w_squash;
            r_inst       <= w_inst;
            r_pc_inc     <= w_pc_inc;
            r_inst_valid <= w_inst_valid;
            r_halted     <= w_halted;
`ifdef ALIGN_CHK_EN
            r_err        <= w_err;
`endif
        end
    end

    // fetch_addr only changes on the cycle an access completes or before
    // one starts, so imem_addr is stable for the whole access.
    assign bus.imem_req   = (r_state == ST_FETCH);
    assign bus.imem_addr  = r_fetch_addr;
    assign bus.inst       = r_inst;
    assign bus.pc_inc     = r_pc_inc;
    assign bus.inst_valid = r_inst_valid;
    assign bus.halted     = r_halted;
`ifdef ALIGN_CHK_EN
    assign bus.err        = r_err;
`else
    assign bus.err        = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized bench for fetch_ctrl: a transaction-level program-flow model predicts each
// cycle's outputs into a queue; an independent monitor pops and compares.
module tb_fetch_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_ctrl_if u_if();

    fetch_ctrl #(.RESET_PC(16'h0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    typedef struct {
        bit          rst;
        bit          req;
        logic [15:0] addr;
        bit          vld;
        logic [15:0] inst;
        logic [15:0] pcinc;
        bit          halted;
        bit          err;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    logic [15:0] mem [256];

    localparam int PH_BOOT = 0;
    localparam int PH_ACC  = 1;
    localparam int PH_SLOT = 2;
    localparam int PH_HLT  = 3;

    // Model: where the program is, described as phases of a single fetch.
    int          ph;
    logic [15:0] m_pc;
    logic [15:0] acc_addr;
    logic [15:0] acc_tgt;
    bit          acc_redir;
    int          acc_age;
    int          n_acc;
    logic [15:0] s_inst;
    logic [15:0] s_pcinc;
    bit          s_halt;
    bit          m_err;
    int          ep;
    int          lat_mode;
    int          rdir_pct;
    int          stall_pct;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: compares every presented cycle against the predicted one.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("imem_req", {15'd0, u_if.imem_req}, {15'd0, e.req});
                if (e.req) chk("imem_addr", u_if.imem_addr, e.addr);
                chk("inst_valid", {15'd0, u_if.inst_valid}, {15'd0, e.vld});
                if (e.vld || e.rst) begin
                    chk("inst", u_if.inst, e.inst);
                    chk("pc_inc", u_if.pc_inc, e.pcinc);
                end
                chk("halted", {15'd0, u_if.halted}, {15'd0, e.halted});
                chk("err", {15'd0, u_if.err}, {15'd0, e.err});
            end
        end
    end

    function automatic logic [15:0] pick_pc();
        case ($urandom_range(0, 7))
            0:       return 16'hFFFE;
            1:       return 16'h0100;
            2:       return 16'h0200;
            3:       return 16'h0010;
            4:       return 16'h0101;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic start_access(input logic [15:0] a);
        m_pc = a;
        n_acc++;
`ifdef ALIGN_CHK_EN
        if (a[0]) begin
            ph    = PH_HLT;
            m_err = 1'b1;
            return;
        end
`endif
        ph        = PH_ACC;
        acc_addr  = a;
        acc_redir = 1'b0;
        acc_age   = 0;
    endtask

    // Apply one cycle of stimulus, predict this cycle's outputs, advance the model.
    task automatic step(input bit redir, input logic [15:0] rpc, input bit stl, input bit dn);
        exp_t e;
        u_if.redirect    = redir;
        u_if.redirect_pc = rpc;
        u_if.stall       = stl;
        u_if.imem_done   = dn;
        u_if.imem_rdata  = dn ? mem[u_if.imem_addr[7:0]] : 16'($urandom);
        e.rst    = 1'b0;
        e.req    = (ph == PH_ACC);
        e.addr   = acc_addr;
        e.vld    = (ph == PH_SLOT);
        e.inst   = s_inst;
        e.pcinc  = s_pcinc;
        e.halted = (ph == PH_HLT);
        e.err    = m_err;
        q.push_back(e);
        case (ph)
            PH_BOOT: start_access(redir ? rpc : m_pc);
            PH_ACC: begin
                acc_age++;
                if (redir) begin
                    acc_redir = 1'b1;
                    acc_tgt   = rpc;
                end
                if (dn) begin
                    if (acc_redir) begin
                        start_access(acc_tgt);
                    end else begin
                        s_inst  = mem[acc_addr[7:0]];
                        s_pcinc = acc_addr + 16'd2;
                        s_halt  = (s_inst[15:11] == 5'd0);
                        m_pc    = s_pcinc;
                        ph      = PH_SLOT;
                    end
                end
            end
            PH_SLOT: begin
                if (redir) start_access(rpc);
                else if (!stl) begin
                    if (s_halt) ph = PH_HLT;
                    else start_access(m_pc);
                end
            end
            default: ;
        endcase
    endtask

    initial begin
        bit          redir;
        bit          stl;
        bit          dn;
        logic [15:0] rpc;
        int          hold;
        exp_t        z;
        u_if.redirect = 1'b0; u_if.redirect_pc = 16'h0; u_if.stall = 1'b0;
        u_if.imem_done = 1'b0; u_if.imem_rdata = 16'h0;
        for (ep = 0; ep < 30; ep++) begin
            for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
            mem[8'hFE] = 16'h8421;
            if (ep == 0) begin
                mem[0] = 16'h4000; mem[2] = 16'h4000; mem[4] = 16'h0000;
            end
            case (ep)
                0, 2, 3: lat_mode = 0;
                1:       lat_mode = 1;
                4, 5:    lat_mode = 2;
                default: lat_mode = $urandom_range(0, 2);
            endcase
            rdir_pct  = (ep >= 6) ? 8 : 0;
            stall_pct = (ep == 2) ? 80 : ((ep >= 6) ? 30 : 0);

            // Reset, possibly in the middle of an access, with noise on the inputs.
            repeat (3) begin
                @(negedge clk);
                rst_n = 1'b0;
                u_if.imem_done   = 1'($urandom);
                u_if.redirect    = 1'($urandom);
                u_if.redirect_pc = 16'($urandom);
                u_if.stall       = 1'($urandom);
                z = '{rst: 1'b1, req: 1'b0, addr: 16'h0, vld: 1'b0, inst: 16'h0,
                      pcinc: 16'h0, halted: 1'b0, err: 1'b0};
                q.push_back(z);
            end
            @(negedge clk);
            rst_n = 1'b1;
            ph = PH_BOOT; m_pc = 16'h0000; m_err = 1'b0; n_acc = 0;
            s_inst = 16'h0; s_pcinc = 16'h0; s_halt = 1'b0;
            acc_addr = 16'h0; acc_tgt = 16'h0; acc_redir = 1'b0; acc_age = 0;
            hold = 0;

            for (int cyc = 0; cyc < 250 && hold < 6; cyc++) begin
                if (cyc > 0) @(negedge clk);
                redir = ($urandom_range(0, 99) < rdir_pct);
                rpc   = pick_pc();
                stl   = ($urandom_range(0, 99) < stall_pct);
                case (lat_mode)
                    0:       dn = 1'b1;
                    1:       dn = (acc_age == 2);
                    default: dn = ($urandom_range(0, 9) < 4);
                endcase
                dn = dn && (ph == PH_ACC);
                if (ph == PH_BOOT) begin
                    case (ep)
                        3:       begin redir = 1'b1; rpc = 16'h0010; end
                        4:       begin redir = 1'b1; rpc = 16'hFFFE; end
                        5:       begin redir = 1'b1; rpc = 16'h0101; end
                        default: if (ep >= 6) redir = 1'($urandom);
                    endcase
                end
                if (ep == 1 && ph == PH_ACC && n_acc == 1 && acc_age == 0) begin
                    redir = 1'b1; rpc = 16'h0100;
                end
                if (ep == 3 && ph == PH_ACC && n_acc == 1) begin
                    redir = 1'b1; rpc = 16'h0200;
                end
                step(redir, rpc, stl, dn);
                if (ph == PH_HLT) hold++;
            end
        end

        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drained: %0d predicted cycles left unchecked, required 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
